// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and alignment check for the memory access unit
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
        return size == SZ_HALF  ? addr[0] :
               size == SZ_WORD  ? |addr[1:0] :
               size == SZ_DWORD ? |addr[2:0] : 1'b0;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, write-data replication and load extraction/extension for one lane offset
module mem_lane_align import mem_access_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int LW     = $clog2(DATA_W / 8)
) (
    input  logic [LW-1:0]     lane_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [NB-1:0]     be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [7:0]        lane_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] size_mask;
    logic              top_bit;

    always_comb begin
        lane_mask = (8'd1 << (4'd1 << size_i)) - 8'd1;
        be_o      = NB'(lane_mask) << lane_i;
        wdata_o   = size_i == SZ_BYTE ? {NB{wdata_i[7:0]}} :
                    size_i == SZ_HALF ? {(NB/2){wdata_i[15:0]}} :
                    size_i == SZ_WORD ? {(NB/4){wdata_i[31:0]}} : wdata_i;
        shifted   = rdata_i >> {lane_i, 3'b000};
        size_mask = size_i == SZ_BYTE ? DATA_W'(8'hFF) :
                    size_i == SZ_HALF ? DATA_W'(16'hFFFF) :
                    size_i == SZ_WORD ? DATA_W'(32'hFFFF_FFFF) : '1;
        top_bit   = size_i == SZ_BYTE ? shifted[7] :
                    size_i == SZ_HALF ? shifted[15] :
                    size_i == SZ_WORD ? shifted[31] : shifted[DATA_W-1];
        // a full-width mask leaves no bits to fill, so signedness drops out there
        rdata_o   = (shifted & size_mask) | ((signed_i && top_bit) ? ~size_mask : '0);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: request/response engine driving RAM strobes with bounded wait and lane-aligned data
module mem_access_unit import mem_access_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   ram_data_in,
    input  logic [DATA_W-1:0]   ram_data_out,
    input  logic                ram_ready,
    output logic                cs,
    output logic                we,
    output logic                oe,
    output logic [DATA_W/8-1:0] be
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic                we_q, we_d, signed_q, signed_d, err_q, err_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NB-1:0]       be_w;
    logic [DATA_W-1:0]   ext_rdata;
    logic                bad;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane_i   (addr_q[LW-1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .rdata_i  (ram_data_out),
        .be_o     (be_w),
        .wdata_o  (ram_data_in),
        .rdata_o  (ext_rdata)
    );

    always_comb begin
        bad      = misaligned(req_size, req_addr[2:0]) || (req_size == SZ_DWORD && DATA_W == 32);
        state_d  = state_q;
        we_d     = we_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (state_q == ST_IDLE && req_valid) begin
            we_d     = req_we;
            signed_d = req_signed;
            size_d   = req_size;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            rdata_d  = '0;
            err_d    = bad;
            cnt_d    = '0;
            state_d  = bad ? ST_RESP : ST_ACCESS;
        end else if (state_q == ST_ACCESS) begin
            if (ram_ready) begin
                rdata_d = we_q ? '0 : ext_rdata;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT)) begin
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready = state_q == ST_IDLE;
    assign cs        = state_q == ST_ACCESS;
    assign we        = cs && we_q;
    assign oe        = cs && !we_q;
    assign be        = cs ? be_w : '0;
    assign address   = {addr_q[ADDR_W-1:LW], LW'(0)};
    assign rsp_valid = state_q == ST_RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed requests with a response scoreboard checked by an independent monitor
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, address, ram_data_in;
    logic [31:0] ram_data_out = '0;
    logic        ram_ready = 1'b0;
    logic        cs, we, oe;
    logic [3:0]  be;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .address(address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_ready(ram_ready),
        .cs(cs), .we(we), .oe(oe), .be(be)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual rsp_valid=1 required none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input bit acc, input int waits, input bit rdy,
                          input logic [31:0] word, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [3:0] exp_be,
                          input logic [31:0] exp_din);
        exp_t e;
        int   t;
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rd = exp_rd; e.err = exp_err; e.at = acc ? cyc + 1 + waits : cyc;
        exp_q.push_back(e);
        if (acc) begin
            for (int k = 0; k <= waits; k++) begin
                @(negedge clk);
                chk("cs_access", cs, 1'b1);
                chk("we_access", we, w);
                chk("oe_access", oe, !w);
                chk("be", be, exp_be);
                chk("address", address, ad & 32'hFFFF_FFFC);
                if (w) chk("ram_data_in", ram_data_in, exp_din);
                ram_data_out = word;
                ram_ready = rdy && (k == waits);
            end
            @(negedge clk);
            ram_ready = 1'b0;
            chk("cs_after", cs, 1'b0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk("cs_noaccess", cs, 1'b0);
            end
        end
        t = 0;
        while (!req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("ready_back", req_ready, 1'b1);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_strobes", {cs, we, oe}, 3'b000);
        chk("rst_be", be, 4'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_ram_data_in", ram_data_in, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // ram_ready while idle must not disturb anything
        ram_ready = 1'b1;
        @(negedge clk);
        ram_ready = 1'b0;
        chk("idle_ready_ignored", {req_ready, cs}, 2'b10);

        //     we   sz    sg    addr          wdata         acc w  rdy word           exp_rd         err   be    din
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        1, 0, 1, 32'h80000000, 32'hFFFFFF80, 1'b0, 4'h8, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        1, 0, 1, 32'h80000000, 32'h00000080, 1'b0, 4'h8, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD,     1, 3, 1, 32'h0,        32'h0,        1'b0, 4'hC, 32'hABCDABCD);
        do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        1, TO, 0, 32'h55AA55AA, 32'h0,       1'b1, 4'hF, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h204, 32'h0,        1, TO, 1, 32'h12345678, 32'h12345678, 1'b0, 4'hF, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        1, 1, 1, 32'h80011234, 32'hFFFF8001, 1'b0, 4'hC, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h000, 32'h0,        1, 0, 1, 32'h1234F00D, 32'h0000F00D, 1'b0, 4'h3, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h301, 32'hFF5A,     1, 0, 1, 32'h0,        32'h0,        1'b0, 4'h2, 32'h5A5A5A5A);
        do_req(1'b1, 2'd2, 1'b0, 32'h308, 32'hCAFEF00D, 1, 2, 1, 32'h0,        32'h0,        1'b0, 4'hF, 32'hCAFEF00D);
        do_req(1'b0, 2'd2, 1'b1, 32'h30C, 32'h0,        1, 0, 1, 32'h80000001, 32'h80000001, 1'b0, 4'hF, 32'h0);

        // reset in the middle of an access: strobes drop at once and no response follows
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h400; req_wdata = 32'h11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_cs", {cs, we, oe}, 3'b110);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_strobes", {cs, we, oe}, 3'b000);
        chk("async_rst_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
